cache_line_fill: RTL and testbench

- Sits directly downstream of the cache back-end AXI read channel during line replacement.
- Consumes that channel's `replace` / `read_valid` / `read_addr` / `read_rdata` beat stream and assembles back-end words into a full-line buffer.
- Commits the assembled line to the cache data memory in a single wide write, and flags fills that end incomplete.
- Optionally forwards the front-end's requested (critical) word as soon as its beat arrives.

---
 rtl/cache_line_fill.sv | 164 ++++++++++++++++
 tb/tb_cache_line_fill.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_fill.sv
// Collects back-end read beats into a line buffer during replacement, then commits the line in a single wide write.
// `define CACHE_FILL_FWD_EN adds a one-shot forward of the critical front-end word as soon as its beat arrives.
module cache_line_fill #(
    parameter int FE_DATA_W  = 32,
    parameter int BE_DATA_W  = FE_DATA_W,
    parameter int WORD_OFF_W = 3,
    parameter int LINE2MEM_W = WORD_OFF_W - $clog2(BE_DATA_W / FE_DATA_W),
    parameter int LINE_W     = FE_DATA_W * (2 ** WORD_OFF_W)
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic                                          replace_i,
    input  logic                                          read_valid_i,
    input  logic [((LINE2MEM_W > 0) ? LINE2MEM_W : 1)-1:0] read_addr_i,
    input  logic [BE_DATA_W-1:0]                          read_rdata_i,
    input  logic [WORD_OFF_W-1:0]                         req_woff_i,
    output logic                                          busy_o,
    output logic                                          line_we_o,
    output logic [LINE_W-1:0]                             line_wdata_o,
    output logic                                          fill_err_o,
    output logic                                          fwd_valid_o,
    output logic [FE_DATA_W-1:0]                          fwd_rdata_o
);

    localparam int NBEATS = 2 ** LINE2MEM_W;
    localparam int ADDR_W = (LINE2MEM_W > 0) ? LINE2MEM_W : 1;

    typedef enum logic [1:0] {IDLE, FILL, COMMIT, ABORT} state_t;

    state_t              state_q;
    logic                rep_q;
    logic                hold_q;
    logic [NBEATS-1:0]   mask_q;
    logic [NBEATS-1:0]   mask_d;
    logic [LINE_W-1:0]   line_q;
    logic                line_we_q;
    logic                fill_err_q;
    logic [ADDR_W-1:0]   beat_idx;
    logic                beat_in;
    logic                fall;
    logic                start;

    generate
        if (LINE2MEM_W > 0) begin : g_multi
            assign beat_idx = read_addr_i;
        end else begin : g_single
            logic unused_addr;
            assign unused_addr = ^read_addr_i;
            assign beat_idx    = '0;
        end
    endgenerate

    assign beat_in = (state_q == FILL) && read_valid_i;
    assign fall    = rep_q && !replace_i;
    // A replace still high from before a reset belongs to a discarded fill.
    assign start   = (state_q == IDLE) && replace_i && !hold_q;

    always_comb begin
        mask_d = mask_q;
        if (beat_in) begin
            mask_d[beat_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            rep_q      <= 1'b0;
            hold_q     <= 1'b1;
            mask_q     <= '0;
            line_q     <= '0;
            line_we_q  <= 1'b0;
            fill_err_q <= 1'b0;
        end else begin
            rep_q      <= replace_i;
            hold_q     <= hold_q && replace_i;
            line_we_q  <= 1'b0;
            fill_err_q <= 1'b0;
            if (beat_in) begin
                line_q[beat_idx*BE_DATA_W +: BE_DATA_W] <= read_rdata_i;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FILL;
                        mask_q  <= '0;
                    end
                end
                FILL: begin
                    mask_q <= mask_d;
                    if (fall) begin
                        if (&mask_d) begin
                            state_q   <= COMMIT;
                            line_we_q <= 1'b1;
                        end else begin
                            state_q    <= ABORT;
                            fill_err_q <= 1'b1;
                        end
                    end
                end
                COMMIT:  state_q <= IDLE;
                ABORT:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o       = (state_q == FILL) || (state_q == COMMIT);
    assign line_we_o    = line_we_q;
    assign line_wdata_o = line_q;
    assign fill_err_o   = fill_err_q;

`ifdef CACHE_FILL_FWD_EN
    localparam int SEL_W = WORD_OFF_W - LINE2MEM_W;

    logic [WORD_OFF_W-1:0] woff_q;
    logic                  fwd_done_q;
    logic                  fwd_valid_q;
    logic [FE_DATA_W-1:0]  fwd_rdata_q;
    logic [FE_DATA_W-1:0]  fe_word;
    logic [ADDR_W-1:0]     crit_slot;

    generate
        if (LINE2MEM_W > 0) begin : g_crit
            assign crit_slot = woff_q[WORD_OFF_W-1 -: LINE2MEM_W];
        end else begin : g_crit_one
            assign crit_slot = '0;
        end
        if (SEL_W > 0) begin : g_sel
            assign fe_word = read_rdata_i[woff_q[SEL_W-1:0]*FE_DATA_W +: FE_DATA_W];
        end else begin : g_nosel
            assign fe_word = read_rdata_i[FE_DATA_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            woff_q      <= '0;
            fwd_done_q  <= 1'b0;
            fwd_valid_q <= 1'b0;
            fwd_rdata_q <= '0;
        end else begin
            fwd_valid_q <= 1'b0;
            if (start) begin
                woff_q     <= req_woff_i;
                fwd_done_q <= 1'b0;
            end else if (beat_in && !fwd_done_q && (beat_idx == crit_slot)) begin
                fwd_valid_q <= 1'b1;
                fwd_rdata_q <= fe_word;
                fwd_done_q  <= 1'b1;
            end
        end
    end

    assign fwd_valid_o = fwd_valid_q;
    assign fwd_rdata_o = fwd_rdata_q;
`else
    logic unused_woff;
    assign unused_woff = ^req_woff_i;
    assign fwd_valid_o = 1'b0;
    assign fwd_rdata_o = '0;
`endif

endmodule

// File: tb/tb_cache_line_fill.sv
// Directed bench for cache_line_fill: a default 8-beat instance and a 64-bit back-end 4-beat instance.
module tb_cache_line_fill;

`ifdef CACHE_FILL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        rep_a, rv_a;
    logic [2:0]  ra_a;
    logic [31:0] rd_a;
    logic [2:0]  woff_a;
    logic        busy_a, we_a, err_a, fv_a;
    logic [255:0] line_a;
    logic [31:0] fr_a;

    logic        rep_b, rv_b;
    logic [1:0]  ra_b;
    logic [63:0] rd_b;
    logic [2:0]  woff_b;
    logic        busy_b, we_b, err_b, fv_b;
    logic [255:0] line_b;
    logic [31:0] fr_b;

    int checks = 0;
    int errors = 0;
    int we_a_cnt = 0, err_a_cnt = 0, we_b_cnt = 0, err_b_cnt = 0, fwd_b_cnt = 0;

    cache_line_fill u_dut_a (
        .clk_i(clk), .reset_i(reset), .replace_i(rep_a), .read_valid_i(rv_a),
        .read_addr_i(ra_a), .read_rdata_i(rd_a), .req_woff_i(woff_a),
        .busy_o(busy_a), .line_we_o(we_a), .line_wdata_o(line_a), .fill_err_o(err_a),
        .fwd_valid_o(fv_a), .fwd_rdata_o(fr_a)
    );

    cache_line_fill #(.FE_DATA_W(32), .BE_DATA_W(64), .WORD_OFF_W(3)) u_dut_b (
        .clk_i(clk), .reset_i(reset), .replace_i(rep_b), .read_valid_i(rv_b),
        .read_addr_i(ra_b), .read_rdata_i(rd_b), .req_woff_i(woff_b),
        .busy_o(busy_b), .line_we_o(we_b), .line_wdata_o(line_b), .fill_err_o(err_b),
        .fwd_valid_o(fv_b), .fwd_rdata_o(fr_b)
    );

    always @(negedge clk) begin
        if (we_a)  we_a_cnt++;
        if (err_a) err_a_cnt++;
        if (we_b)  we_b_cnt++;
        if (err_b) err_b_cnt++;
        if (fv_b)  fwd_b_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_beats_a(input logic [31:0] base, input int gap, input int n);
        for (int i = 0; i < n; i++) begin
            rv_a = 1'b1;
            ra_a = i[2:0];
            rd_a = base + 32'(i);
            tick();
            rv_a = 1'b0;
            repeat (gap) tick();
        end
        rv_a = 1'b0;
    endtask

    function automatic logic [255:0] line_pat(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    function automatic logic [63:0] beat_b(input int i, input bit second);
        logic [63:0] d;
        if (second)      d = {32'h5555_0000 + 32'(i), 32'h6666_0000 + 32'(i)};
        else if (i == 2) d = 64'hCCCC_DDDD_AAAA_BBBB;
        else             d = {32'h0F0F_0000 + 32'(i), 32'h0E0E_0000 + 32'(i)};
        return d;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        rep_a = 0; rv_a = 0; ra_a = 0; rd_a = 0; woff_a = 0;
        rep_b = 0; rv_b = 0; ra_b = 0; rd_b = 0; woff_b = 0;
        tick(); tick();
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a got %b want 0", busy_a); end
        checks++; if (we_a !== 1'b0) begin errors++; $display("FAIL reset_we_a got %b want 0", we_a); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err_a got %b want 0", err_a); end
        checks++; if (line_a !== 256'd0) begin errors++; $display("FAIL reset_line_a got %h want 0", line_a); end
        checks++; if (fv_a !== 1'b0 || fr_a !== 32'd0) begin errors++; $display("FAIL reset_fwd_a got %b/%h want 0/0", fv_a, fr_a); end
        checks++; if (busy_b !== 1'b0 || line_b !== 256'd0) begin errors++; $display("FAIL reset_b got busy %b line %h want 0", busy_b, line_b); end
        reset = 1'b0;
        tick(); tick();
    endtask

    task automatic test_full_fill;
        int w0, e0;
        logic [255:0] exp;
        exp = line_pat(32'h1000_0000);
        w0 = we_a_cnt; e0 = err_a_cnt;
        rep_a = 1'b1;
        tick();
        send_beats_a(32'h1000_0000, 0, 8);
        checks++; if (we_a !== 1'b0) begin errors++; $display("FAIL full_we_early got %b want 0", we_a); end
        rep_a = 1'b0;
        tick();
        checks++; if (we_a !== 1'b1) begin errors++; $display("FAIL full_we_pulse got %b want 1", we_a); end
        checks++; if (line_a[31:0] !== 32'h1000_0000) begin errors++; $display("FAIL full_word0 got %h want 10000000", line_a[31:0]); end
        checks++; if (line_a[255:224] !== 32'h1000_0007) begin errors++; $display("FAIL full_word7 got %h want 10000007", line_a[255:224]); end
        checks++; if (line_a !== exp) begin errors++; $display("FAIL full_line got %h want %h", line_a, exp); end
        tick();
        checks++; if (we_a !== 1'b0) begin errors++; $display("FAIL full_we_end got %b want 0", we_a); end
        checks++; if (we_a_cnt - w0 !== 1) begin errors++; $display("FAIL full_we_count got %0d want 1", we_a_cnt - w0); end
        checks++; if (err_a_cnt - e0 !== 0) begin errors++; $display("FAIL full_err_count got %0d want 0", err_a_cnt - e0); end
    endtask

    task automatic test_gapped_fill;
        logic [255:0] exp;
        exp = line_pat(32'h1000_0000);
        rep_a = 1'b1;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL gap_busy_idle got %b want 0", busy_a); end
        tick();
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL gap_busy_start got %b want 1", busy_a); end
        for (int i = 0; i < 8; i++) begin
            send_beats_a(32'h1000_0000 + 32'(i) - 32'(i), 0, 0);
            rv_a = 1'b1; ra_a = i[2:0]; rd_a = 32'h1000_0000 + 32'(i);
            tick();
            rv_a = 1'b0;
            tick(); tick();
            checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL gap_busy beat %0d got %b want 1", i, busy_a); end
        end
        rep_a = 1'b0;
        tick();
        checks++; if (we_a !== 1'b1 || busy_a !== 1'b1) begin errors++; $display("FAIL gap_commit got we %b busy %b want 1 1", we_a, busy_a); end
        checks++; if (line_a !== exp) begin errors++; $display("FAIL gap_line got %h want %h", line_a, exp); end
        tick();
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL gap_busy_end got %b want 0", busy_a); end
    endtask

    task automatic test_retry;
        int w0;
        logic [255:0] exp;
        exp = line_pat(32'h600D_0000);
        w0 = we_a_cnt;
        rep_a = 1'b1;
        tick();
        send_beats_a(32'hBAD0_0000, 0, 8);
        send_beats_a(32'h600D_0000, 0, 8);
        checks++; if (we_a !== 1'b0) begin errors++; $display("FAIL retry_no_early_we got %b want 0", we_a); end
        rep_a = 1'b0;
        tick();
        checks++; if (line_a !== exp) begin errors++; $display("FAIL retry_line got %h want %h", line_a, exp); end
        tick();
        checks++; if (we_a_cnt - w0 !== 1) begin errors++; $display("FAIL retry_we_count got %0d want 1", we_a_cnt - w0); end
    endtask

    task automatic test_abort;
        int w0, e0;
        logic [255:0] exp;
        exp = line_pat(32'h2000_0000);
        w0 = we_a_cnt; e0 = err_a_cnt;
        rep_a = 1'b1;
        tick();
        send_beats_a(32'h3000_0000, 0, 5);
        rep_a = 1'b0;
        tick();
        checks++; if (err_a !== 1'b1 || we_a !== 1'b0) begin errors++; $display("FAIL abort_pulse got err %b we %b want 1 0", err_a, we_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy_a); end
        tick();
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL abort_err_end got %b want 0", err_a); end
        checks++; if (err_a_cnt - e0 !== 1 || we_a_cnt - w0 !== 0) begin errors++; $display("FAIL abort_counts got err %0d we %0d want 1 0", err_a_cnt - e0, we_a_cnt - w0); end
        rep_a = 1'b1;
        tick();
        send_beats_a(32'h2000_0000, 0, 8);
        rep_a = 1'b0;
        tick();
        checks++; if (we_a !== 1'b1 || line_a !== exp) begin errors++; $display("FAIL abort_refill got we %b line %h want 1 %h", we_a, line_a, exp); end
        tick();
        checks++; if (err_a_cnt - e0 !== 1 || we_a_cnt - w0 !== 1) begin errors++; $display("FAIL abort_refill_counts got err %0d we %0d want 1 1", err_a_cnt - e0, we_a_cnt - w0); end
    endtask

    task automatic test_back_to_back;
        int w0;
        logic [255:0] exp1, exp2;
        exp1 = line_pat(32'h4000_0000);
        exp2 = line_pat(32'h5000_0000);
        w0 = we_a_cnt;
        rep_a = 1'b1;
        tick();
        send_beats_a(32'h4000_0000, 0, 8);
        rep_a = 1'b0;
        tick();
        checks++; if (we_a !== 1'b1) begin errors++; $display("FAIL b2b_first_we got %b want 1", we_a); end
        rep_a = 1'b1;
        tick();
        checks++; if (busy_a !== 1'b0 || line_a !== exp1) begin errors++; $display("FAIL b2b_gap got busy %b line %h want 0 %h", busy_a, line_a, exp1); end
        tick();
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL b2b_restart got %b want 1", busy_a); end
        send_beats_a(32'h5000_0000, 0, 8);
        rep_a = 1'b0;
        tick();
        checks++; if (we_a !== 1'b1 || line_a !== exp2) begin errors++; $display("FAIL b2b_second got we %b line %h want 1 %h", we_a, line_a, exp2); end
        tick();
        checks++; if (we_a_cnt - w0 !== 2) begin errors++; $display("FAIL b2b_we_count got %0d want 2", we_a_cnt - w0); end
    endtask

    task automatic test_forward;
        int f0, w0;
        logic [255:0] exp;
        logic [31:0] want_rd;
        for (int i = 0; i < 4; i++) exp[i*64 +: 64] = beat_b(i, 1'b1);
        want_rd = FWD ? 32'hCCCC_DDDD : 32'd0;
        f0 = fwd_b_cnt; w0 = we_b_cnt;
        woff_b = 3'd5;
        rep_b  = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            rv_b = 1'b1; ra_b = i[1:0]; rd_b = beat_b(i, 1'b0);
            tick();
            checks++;
            if (fv_b !== ((i == 2) ? FWD : 1'b0)) begin
                errors++; $display("FAIL fwd_valid after beat %0d got %b want %b", i, fv_b, (i == 2) ? FWD : 1'b0);
            end
            if (i == 2) begin
                checks++; if (fr_b !== want_rd) begin errors++; $display("FAIL fwd_rdata got %h want %h", fr_b, want_rd); end
            end
        end
        rv_b = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            rv_b = 1'b1; ra_b = i[1:0]; rd_b = beat_b(i, 1'b1);
            tick();
        end
        rv_b = 1'b0; rep_b = 1'b0;
        tick();
        checks++; if (we_b !== 1'b1 || line_b !== exp) begin errors++; $display("FAIL fwd_commit got we %b line %h want 1 %h", we_b, line_b, exp); end
        tick();
        checks++; if (fwd_b_cnt - f0 !== (FWD ? 1 : 0)) begin errors++; $display("FAIL fwd_count got %0d want %0d", fwd_b_cnt - f0, FWD ? 1 : 0); end
        checks++; if (fr_b !== want_rd) begin errors++; $display("FAIL fwd_rdata_hold got %h want %h", fr_b, want_rd); end
        checks++; if (we_b_cnt - w0 !== 1 || err_b_cnt !== 0) begin errors++; $display("FAIL fwd_b_counts got we %0d err %0d want 1 0", we_b_cnt - w0, err_b_cnt); end
    endtask

    task automatic test_reset_mid_fill;
        int w0, e0;
        logic [255:0] exp;
        exp = line_pat(32'h8000_0000);
        w0 = we_a_cnt; e0 = err_a_cnt;
        rep_a = 1'b1;
        tick();
        send_beats_a(32'h7000_0000, 0, 4);
        reset = 1'b1;
        tick();
        checks++; if (busy_a !== 1'b0 || we_a !== 1'b0 || err_a !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl got busy %b we %b err %b want 0 0 0", busy_a, we_a, err_a); end
        checks++; if (line_a !== 256'd0 || fv_a !== 1'b0 || fr_a !== 32'd0) begin errors++; $display("FAIL rst_mid_data got line %h fwd %b/%h want 0", line_a, fv_a, fr_a); end
        reset = 1'b0;
        tick(); tick();
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_mid_stale_busy got %b want 0", busy_a); end
        rep_a = 1'b0;
        tick(); tick(); tick();
        checks++; if (we_a_cnt - w0 !== 0 || err_a_cnt - e0 !== 0) begin errors++; $display("FAIL rst_mid_counts got we %0d err %0d want 0 0", we_a_cnt - w0, err_a_cnt - e0); end
        rep_a = 1'b1;
        tick();
        send_beats_a(32'h8000_0000, 0, 8);
        rep_a = 1'b0;
        tick();
        checks++; if (we_a !== 1'b1 || line_a !== exp) begin errors++; $display("FAIL rst_mid_refill got we %b line %h want 1 %h", we_a, line_a, exp); end
        tick();
    endtask

    initial begin
        test_reset();
        test_full_fill();
        test_gapped_fill();
        test_retry();
        test_abort();
        test_back_to_back();
        test_forward();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
